// File: rtl/fxp_pkg.sv
// Shared constants and saturation-limit helper for the fixed-point arithmetic blocks.
package fxp_pkg;
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Limits are carried wide enough to compare any pre-saturation value up to 127 bits.
  localparam int LIM_W = 128;

  typedef struct packed {
    logic [LIM_W-1:0] max_v;
    logic [LIM_W-1:0] min_v;
  } sat_lim_t;

  function automatic sat_lim_t sat_limits(input int unsigned width);
    sat_lim_t lim;
    lim.max_v = (LIM_W'(1) << (width - 1)) - LIM_W'(1);
    lim.min_v = ~lim.max_v;
    return lim;
  endfunction
endpackage

// File: rtl/fxp_round_sat.sv
// Combinational shift / round / saturate of a signed fixed-point value; flags out-of-range.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int IN_W     = 64,
  parameter int DROP     = 16,
  parameter int OUT_W    = 32,
  parameter int ROUND    = ROUND_HALF_UP,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);
  localparam int       SH_W = IN_W + 1 - DROP;
  localparam sat_lim_t LIM  = sat_limits(OUT_W);
  localparam logic [IN_W:0] HALF =
    (ROUND == ROUND_HALF_UP) ? ((IN_W + 1)'(1) << (DROP - 1)) : '0;

  logic [IN_W:0]    x_rnd;
  logic [SH_W-1:0]  sh;
  logic [LIM_W-1:0] sx;
  logic             hi;
  logic             lo;

  always_comb begin
    // One guard bit above the sign keeps the rounding add from overflowing.
    x_rnd = {x[IN_W-1], x} + HALF;
    sh    = SH_W'(x_rnd >> DROP);
    sx    = {{(LIM_W - SH_W){sh[SH_W-1]}}, sh};
    hi    = $signed(sx) > $signed(LIM.max_v);
    lo    = $signed(sx) < $signed(LIM.min_v);
    ovf   = hi | lo;
    y     = sx[OUT_W-1:0];
    if (SATURATE != 0) begin
      if (hi) y = LIM.max_v[OUT_W-1:0];
      else if (lo) y = LIM.min_v[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control,
// rounding, saturation and a sticky overflow flag.
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INT_WIDTH   = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int OUT_FRAC    = 16,
  parameter int BIT_SHIFT   = 0,
  parameter int ROUND       = ROUND_HALF_UP,
  parameter int SATURATE    = 1,
  parameter int PIPE_STAGES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [OUT_WIDTH-1:0]  p,
  output logic                         ovf,
  input  logic                         ovf_clr
);
  localparam int FRAC = DATA_WIDTH - INT_WIDTH;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int DROP = 2 * FRAC - OUT_FRAC + BIT_SHIFT;
  localparam int MID  = PIPE_STAGES - 2;

  if (DROP < 1) begin : g_chk_drop
    $error("fxp_mult_pipe: at least one product LSB must be dropped");
  end
  if (PIPE_STAGES < 2 || PIPE_STAGES > 6) begin : g_chk_stages
    $error("fxp_mult_pipe: PIPE_STAGES must be in 2..6");
  end
  if (DATA_WIDTH > 63) begin : g_chk_width
    $error("fxp_mult_pipe: DATA_WIDTH above 63 exceeds the saturation compare width");
  end

  logic                         adv;
  logic                         v1;
  logic signed [DATA_WIDTH-1:0] a_q;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic signed [PW-1:0]         prod_s1;
  logic signed [PW-1:0]         last_prod;
  logic                         last_vld;
  logic signed [OUT_WIDTH-1:0]  rs_val;
  logic                         rs_ovf;

  // Global advance: a stalled output freezes every stage, so nothing is lost or repeated.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v1 <= 1'b0;
    else if (adv) v1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign prod_s1 = PW'(a_q) * PW'(b_q);

  if (MID == 0) begin : g_nomid
    assign last_prod = prod_s1;
    assign last_vld  = v1;
  end else begin : g_mid
    logic signed [PW-1:0] pr_q [MID];
    logic                 vm_q [MID];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MID; i++) vm_q[i] <= 1'b0;
      end else if (adv) begin
        vm_q[0] <= v1;
        for (int i = 1; i < MID; i++) vm_q[i] <= vm_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        pr_q[0] <= prod_s1;
        for (int i = 1; i < MID; i++) pr_q[i] <= pr_q[i-1];
      end
    end

    assign last_prod = pr_q[MID-1];
    assign last_vld  = vm_q[MID-1];
  end

  fxp_round_sat #(
    .IN_W    (PW),
    .DROP    (DROP),
    .OUT_W   (OUT_WIDTH),
    .ROUND   (ROUND),
    .SATURATE(SATURATE)
  ) u_round_sat (
    .x  (last_prod),
    .y  (rs_val),
    .ovf(rs_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= last_vld;
        if (last_vld) p <= rs_val;
      end
      // A fresh overflow wins over a same-cycle clear.
      ovf <= (ovf & !ovf_clr) | (adv & last_vld & rs_ovf);
    end
  end
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Self-checking bench: a rounding/saturating instance and a truncating/wrapping
// instance share stimulus and are compared against an arithmetic reference model.
module tb_fxp_mult_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready0, in_ready1;
  logic        ov0, ov1;
  logic        ovf0, ovf1;
  logic [31:0] p0, p1;

  always #5 clk = ~clk;

  fxp_mult_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
    .p(p0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  fxp_mult_pipe #(.ROUND(0), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
    .p(p1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    got   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q16.16 x Q16.16 -> Q16.16 computed on 64-bit integers.
  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input bit rnd, input bit sat, output bit ov);
    longint pr, sh;
    pr = longint'($signed(ma)) * longint'($signed(mb));
    if (rnd) pr = pr + 64'sd32768;
    sh = pr >>> 16;
    ov = (sh > 64'sd2147483647) || (sh < -64'sd2147483648);
    if (sat && sh > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sat && sh < -64'sd2147483648) return 32'h8000_0000;
    return 32'(sh);
  endfunction

  always @(posedge clk)
    if (!rst && in_valid && in_ready0) exp_q.push_back('{a, b});

  bit          held = 1'b0;
  logic [31:0] hp0, hp1;

  always @(negedge clk) begin
    if (!rst) begin
      beat_t       e;
      bit          o0, o1;
      logic [31:0] e0, e1;
      chk("in_ready", in_ready0, !ov0 | out_ready);
      chk("in_ready_match", in_ready1, in_ready0);
      chk("valid_match", ov1, ov0);
      if (held) begin
        chk("hold_valid", ov0, 1'b1);
        chk("hold_p0", p0, hp0);
        chk("hold_p1", p1, hp1);
      end
      if (ov0 && out_ready) begin
        total++;
        assert (exp_q.size() != 0)
        else begin
          bad++;
          $error("FAIL stale_beat observed=out_valid expected=no_pending_beat");
        end
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          e0 = model(e.a, e.b, 1'b1, 1'b1, o0);
          e1 = model(e.a, e.b, 1'b0, 1'b0, o1);
          chk("p_round_sat", p0, e0);
          chk("p_trunc_wrap", p1, e1);
          if (o0) chk("ovf_set0", ovf0, 1'b1);
          if (o1) chk("ovf_set1", ovf1, 1'b1);
          got++;
        end
      end
      held = ov0 && !out_ready;
      hp0  = p0;
      hp1  = p1;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_wait(input logic [31:0] ta, input logic [31:0] tb_);
    int n = 0;
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!ov0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (ov0)
    else begin
      bad++;
      $error("FAIL send_timeout observed=out_valid_low expected=out_valid_high");
    end
  endtask

  beat_t stim[20];
  int    sent, cyc, got0, stale;
  bit    acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid0", ov0, 1'b0);
    chk("rst_valid1", ov1, 1'b0);
    chk("rst_p0", p0, 32'h0);
    chk("rst_p1", p1, 32'h0);
    chk("rst_ovf0", ovf0, 1'b0);
    chk("rst_in_ready0", in_ready0, 1'b1);
    chk("rst_in_ready1", in_ready1, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: accepted at the next edge, visible in the third cycle after it.
    a = 32'h0001_8000; b = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1", ov0, 1'b0);
    @(negedge clk); chk("lat_cycle2", ov0, 1'b0);
    @(negedge clk);
    chk("lat_cycle3", ov0, 1'b1);
    chk("p_1p5x2", p0, 32'h0003_0000);
    chk("ovf_1p5x2", ovf0, 1'b0);

    send_wait(32'hFFFE_8000, 32'h0002_0000);
    chk("p_neg_r", p0, 32'hFFFD_0000);
    chk("p_neg_t", p1, 32'hFFFD_0000);

    send_wait(32'h0000_0001, 32'h0000_8000);
    chk("p_halfup", p0, 32'h0000_0001);
    chk("p_trunc", p1, 32'h0000_0000);

    send_wait(32'h7FFF_0000, 32'h0002_0000);
    chk("p_sat_hi", p0, 32'h7FFF_FFFF);
    chk("p_wrap_hi", p1, 32'hFFFE_0000);
    chk("ovf_sat", ovf0, 1'b1);
    chk("ovf_wrap", ovf1, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky0", ovf0, 1'b1);
    chk("ovf_sticky1", ovf1, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr0", ovf0, 1'b0);
    chk("ovf_clr1", ovf1, 1'b0);

    // Clear coinciding with a new overflow reaching the output.
    a = 32'h7FFF_0000; b = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_race_valid", ov0, 1'b1);
    chk("clr_race_ovf0", ovf0, 1'b1);
    chk("clr_race_ovf1", ovf1, 1'b1);

    send_wait(32'h8000_0000, 32'h7FFF_0000);
    chk("p_sat_lo", p0, 32'h8000_0000);
    chk("p_wrap_lo", p1, 32'h8000_0000);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // Stream of 20 random beats under out_ready pattern 1,0,0,0.
    for (int i = 0; i < 20; i++) begin
      stim[i].a = 32'($signed($urandom()) >>> $urandom_range(0, 14));
      stim[i].b = 32'($signed($urandom()) >>> $urandom_range(0, 14));
    end
    sent = 0; cyc = 0; got0 = got;
    while (sent < 20 && cyc < 200) begin
      out_ready = (cyc % 4 == 0);
      a = stim[sent].a;
      b = stim[sent].b;
      in_valid = 1'b1;
      #1 acc = in_ready0;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, 20);
    while (got - got0 < 20 && cyc < 400) begin
      out_ready = (cyc % 4 == 0);
      @(posedge clk);
      #1 cyc++;
    end
    chk("stream_received", got - got0, 20);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream_no_extra", exp_q.size(), 0);

    // Reset with three beats in flight, the oldest one overflowing.
    a = 32'h7FFF_0000; b = 32'h0002_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 32'h0000_4000; b = 32'h0001_0000;
    @(posedge clk);
    #1 a = 32'h0003_0000; b = 32'h0000_8000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst_valid", ov0, 1'b1);
    chk("pre_rst_ovf", ovf0, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid0", ov0, 1'b0);
    chk("mid_rst_valid1", ov1, 1'b0);
    chk("mid_rst_ovf0", ovf0, 1'b0);
    chk("mid_rst_ovf1", ovf1, 1'b0);
    chk("mid_rst_p0", p0, 32'h0);
    chk("mid_rst_p1", p1, 32'h0);
    chk("mid_rst_in_ready", in_ready0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov0 || ov1) stale++;
    end
    chk("no_stale_after_rst", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fxp_mult_pipe.md
FXP_MULT_PIPE -- requirements
Module: fxp_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each signed input operand.
REQ-002 SHALL have parameter INT_WIDTH, default 16: integer bits of each input, so the input fraction is FRAC = DATA_WIDTH-INT_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 32: width of the signed result.
REQ-004 SHALL have parameter OUT_FRAC, default 16: fraction bits of the result.
REQ-005 SHALL have parameter BIT_SHIFT, default 0: the result is scaled by 2^-BIT_SHIFT.
REQ-006 SHALL have parameter ROUND, default 1: 0 truncates toward minus infinity; 1 rounds half up.
REQ-007 SHALL have parameter SATURATE, default 1: 0 wraps; 1 clamps.
REQ-008 SHALL have parameter PIPE_STAGES, default 3, legal range 2..6: latency in cycles.
REQ-009 clk  input  1  single clock; all state is updated on its rising edge.
REQ-010 rst  input  1  asynchronous, active-high reset.
REQ-011 in_valid  input  1  the operands are valid.
REQ-012 in_ready  output  1  the block accepts operands this cycle.
REQ-013 a, b  input  DATA_WIDTH each  signed operands.
REQ-014 out_valid  output  1  p is valid.
REQ-015 out_ready  input  1  downstream accepts p.
REQ-016 p  output  OUT_WIDTH  signed result.
REQ-017 ovf  output  1  sticky flag: a result was clamped or wrapped.
REQ-018 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-019 SHALL form the full signed product of width 2*DATA_WIDTH, with 2*FRAC fraction bits.
REQ-020 SHALL drop D = 2*FRAC-OUT_FRAC+BIT_SHIFT LSBs; D >= 1 SHALL be enforced by an elaboration-time check.
REQ-021 With ROUND=1, SHALL add 2^(D-1) to the full product before dropping bits, with no intermediate overflow.
REQ-022 With SATURATE=1, a shifted value above 2^(OUT_WIDTH-1)-1 SHALL give 0x7FF..F, and one below -2^(OUT_WIDTH-1) SHALL give 0x800..0.
REQ-023 With SATURATE=0, SHALL output the low OUT_WIDTH bits of the shifted value.
REQ-024 Any out-of-range result SHALL set ovf on the cycle that result's out_valid first rises, in both modes.
REQ-025 ovf SHALL stay high until ovf_clr; if a new overflow and ovf_clr occur in the same cycle, ovf SHALL stay 1.
REQ-026 The pipeline SHALL advance when adv = !out_valid | out_ready; in_ready SHALL equal adv, computed combinationally.
REQ-027 An operand pair SHALL be captured when in_valid & in_ready.
REQ-028 Its result SHALL appear PIPE_STAGES cycles later when out_ready is held high, giving throughput of one result per cycle.
REQ-029 Each stage SHALL carry a valid bit; bubbles SHALL propagate and SHALL NOT stall later stages.
REQ-030 While out_valid & !out_ready, p, out_valid and all stages SHALL hold; no beat SHALL be lost or duplicated.
REQ-031 Stage 1 SHALL register a and b; the middle stages SHALL register the product; the last stage SHALL register the rounded and saturated p.

Reset
REQ-032 On rst, SHALL clear all stage valid bits, out_valid and ovf immediately.
REQ-033 On rst, p SHALL be 0.
REQ-034 Reset mid-stream SHALL discard every in-flight beat.
REQ-035 in_ready SHALL be 1 while and after rst.
REQ-036 Data registers other than p need not be reset.

Structure
REQ-037 Shared package fxp_pkg SHALL hold the ROUND_TRUNC/ROUND_HALF_UP constants and a function returning the saturation limits for a given width.
REQ-038 The sub-module fxp_round_sat SHALL be a combinational shift, round and saturate unit that outputs a value and an overflow flag; the multiply stays inline.

Verification (DATA_WIDTH=32, INT_WIDTH=16, OUT_WIDTH=32, OUT_FRAC=16, BIT_SHIFT=0, PIPE_STAGES=3 unless stated)
REQ-039 a=0x00018000, b=0x00020000, out_ready=1 -> p=0x00030000 exactly 3 cycles after acceptance, ovf=0.
REQ-040 a=0xFFFE8000, b=0x00020000 -> p=0xFFFD0000.
REQ-041 a=0x00000001, b=0x00008000: ROUND=1 -> p=0x00000001; ROUND=0 -> p=0x00000000.
REQ-042 a=0x7FFF0000, b=0x00020000: SATURATE=1 -> p=0x7FFFFFFF, ovf=1 and held until ovf_clr pulse; SATURATE=0 -> p=0xFFFE0000, ovf=1.
REQ-043 Stream of 20 beats, out_ready pattern 1,0,0,0,1,... -> all 20 results in order, none lost or duplicated, in_ready low exactly while stalled.
REQ-044 Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and ovf=0 at once, p=0, no stale beat emitted afterwards.
